// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM encoding and op classification for the multiply/divide unit
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
  localparam logic [3:0] OP_MADD  = 4'b1000;
  localparam logic [3:0] OP_MADDU = 4'b1001;
  localparam logic [3:0] OP_MSUB  = 4'b1010;
  localparam logic [3:0] OP_MSUBU = 4'b1011;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;
  function automatic logic op_mul(input logic [3:0] op);
    return op == OP_MULT || op == OP_MULTU;
  endfunction
  function automatic logic op_div(input logic [3:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
  function automatic logic op_acc(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction
  function automatic logic op_sub(input logic [3:0] op);
    return op == OP_MSUB || op == OP_MSUBU;
  endfunction
  function automatic logic op_signed(input logic [3:0] op);
    return op == OP_MULT || op == OP_DIV || op == OP_MADD || op == OP_MSUB;
  endfunction
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-divide iteration (shift in next dividend bit, trial subtract)
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0] sh, df;
  always_comb begin
    sh = {rem, quo[WIDTH-1]};
    df = sh - {1'b0, dvs};
    rem_n = df[WIDTH] ? sh[WIDTH-1:0] : df[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ~df[WIDTH]};
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 iterative multiply/divide owning HI/LO
// Defining MDU_ACCUM_EN enables MADD/MADDU/MSUB/MSUBU accumulate into {hi,lo}.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] wk_hi, wk_lo, dvs, a_q, div_rem, div_quo, quo_fix, rem_fix;
  logic [WIDTH:0] mul_sum;
  logic [2*WIDTH-1:0] prod, sprod, mul_res, res;
  logic div_q, neg_res, neg_rem, bz, sgn, iter, accept, last;
`ifdef MDU_ACCUM_EN
  logic acc_q, sub_q;
  assign iter = op_mul(op) || op_div(op) || op_acc(op);
`else
  assign iter = op_mul(op) || op_div(op);
`endif
  assign sgn = op_signed(op);
  assign accept = state == ST_IDLE && start && !flush;
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_n;
  always_comb
    state_n = flush ? ST_IDLE :
              state == ST_IDLE ? (start && iter ? ST_RUN : ST_IDLE) :
              state == ST_RUN  ? (last ? ST_FIX : ST_RUN) : ST_IDLE;
  always_comb busy = state != ST_IDLE;
  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem(wk_hi), .quo(wk_lo), .dvs(dvs), .rem_n(div_rem), .quo_n(div_quo)
  );
  // shift-add multiply: {wk_hi,wk_lo} holds partial product above the unconsumed multiplier bits
  assign mul_sum = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, dvs} : '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      wk_hi <= '0;
      wk_lo <= '0;
      dvs <= '0;
      a_q <= '0;
      div_q <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      bz <= 1'b0;
`ifdef MDU_ACCUM_EN
      acc_q <= 1'b0;
      sub_q <= 1'b0;
`endif
    end else if (accept && iter) begin
      cnt <= '0;
      wk_hi <= '0;
      wk_lo <= sgn && a[WIDTH-1] ? -a : a;
      dvs <= sgn && b[WIDTH-1] ? -b : b;
      a_q <= a;
      div_q <= op_div(op);
      neg_res <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem <= sgn && a[WIDTH-1];
      bz <= b == '0;
`ifdef MDU_ACCUM_EN
      acc_q <= op_acc(op);
      sub_q <= op_sub(op);
`endif
    end else if (state == ST_RUN) begin
      cnt <= cnt + 1'b1;
      wk_hi <= div_q ? div_rem : mul_sum[WIDTH:1];
      wk_lo <= div_q ? div_quo : {mul_sum[0], wk_lo[WIDTH-1:1]};
    end
  always_comb begin
    prod = {wk_hi, wk_lo};
    sprod = neg_res ? -prod : prod;
    quo_fix = neg_res ? -wk_lo : wk_lo;
    rem_fix = neg_rem ? -wk_hi : wk_hi;
`ifdef MDU_ACCUM_EN
    mul_res = acc_q ? {hi, lo} + (sub_q ? -sprod : sprod) : sprod;
`else
    mul_res = sprod;
`endif
    res = !div_q ? mul_res : bz ? {a_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= state == ST_FIX && !flush;
      if (state == ST_FIX && !flush) {hi, lo} <= res;
      else if (accept && op == OP_MTHI) hi <= a;
      else if (accept && op == OP_MTLO) lo <= a;
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit; honours MDU_ACCUM_EN
module tb_mul_div_unit;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, flush = 1'b0;
  logic [3:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  typedef struct {string tag; logic [63:0] v;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int vectors = 0, miscompares = 0;
  logic [31:0] mhi = '0, mlo = '0;
  logic done_prev = 1'b0;
  always #5 clk = ~clk;
  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit is_iter(input logic [3:0] o);
`ifdef MDU_ACCUM_EN
    return o <= 4'd3 || (o >= 4'd8 && o <= 4'd11);
`else
    return o <= 4'd3;
`endif
  endfunction
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                        input logic [63:0] acc);
    longint sx, sy;
    logic [63:0] p;
    int q, r;
    sx = $signed(x);
    sy = $signed(y);
    p = (o[0] == 1'b0) ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
    if (o == 4'd8 || o == 4'd9) return acc + p;
    if (o == 4'd10 || o == 4'd11) return acc - p;
    if (o == 4'd2 || o == 4'd3) begin
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (o == 4'd3) return {x % y, x / y};
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
      return {r, q};
    end
    return p;
  endfunction
  always @(posedge clk) begin
    #1;
    if (done) begin
      chk("done_width", done_prev, 0);
      if (sb.size() == 0) chk("unexpected_done", done, 0);
      else begin
        mon_e = sb.pop_front();
        chk(mon_e.tag, {hi, lo}, mon_e.v);
      end
    end
    done_prev = done;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    logic [63:0] e;
    n = 0;
    op = o; a = x; b = y; start = 1'b1;
    tick(1);
    start = 1'b0;
    if (is_iter(o)) begin
      e = model(o, x, y, {mhi, mlo});
      sb.push_back('{tag, e});
      {mhi, mlo} = e;
      while (busy && n < 40) begin
        n++;
        tick(1);
      end
      chk({tag, ".busy_cycles"}, n, 33);
      chk({tag, ".done"}, done, 1);
    end else begin
      if (o == 4'd4) mhi = x;
      if (o == 4'd5) mlo = x;
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".hi"}, hi, mhi);
      chk({tag, ".lo"}, lo, mlo);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #2 rst_n = 1'b0;
    tick(2);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    rst_n = 1'b1;
    tick(1);
    issue("mult_neg", 4'd0, 32'hFFFF_FFFD, 32'd7);
    issue("multu_max", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue("div_neg", 4'd2, 32'hFFFF_FFF9, 32'd2);
    issue("divu_by0", 4'd3, 32'd7, 32'd0);
    issue("div_min", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue("div_by0_s", 4'd2, 32'hFFFF_FFF9, 32'd0);
    issue("div_pos_neg", 4'd2, 32'd7, 32'hFFFF_FFFE);
    issue("mthi", 4'd4, 32'h1234, 32'd0);
    issue("mtlo", 4'd5, 32'h5678, 32'd0);
    issue("noop", 4'd6, 32'hDEAD, 32'hBEEF);
    for (int i = 0; i < 8; i++)
      issue("rand", 4'($urandom_range(0, 3)), $urandom, (i % 2) ? $urandom : $urandom_range(1, 100));
    op = 4'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    op = 4'd4; a = 32'hDEAD_BEEF; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_start.hi", hi, mhi);
    chk("busy_start.busy", busy, 1);
    tick(4);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush.busy", busy, 0);
    chk("flush.done", done, 0);
    tick(40);
    chk("flush.hi", hi, mhi);
    chk("flush.lo", lo, mlo);
    op = 4'd0; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    tick(1);
    chk("flush_start.busy", busy, 0);
    op = 4'd4; a = 32'hCAFE;
    tick(1);
    start = 1'b0; flush = 1'b0;
    chk("flush_mthi.hi", hi, mhi);
    op = 4'd1; a = 32'hFFFF; b = 32'hFFFF; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.done", done, 0);
    chk("rst_mid.hi", hi, 0);
    chk("rst_mid.lo", lo, 0);
    mhi = '0; mlo = '0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    issue("mtlo5", 4'd5, 32'd5, 32'd0);
    issue("mthi0", 4'd4, 32'd0, 32'd0);
    issue("madd", 4'd8, 32'd2, 32'd3);
    issue("msub", 4'd10, 32'hFFFF_FFFF, 32'd4);
    issue("maddu", 4'd9, 32'hFFFF_FFFF, 32'd2);
    issue("msubu", 4'd11, 32'h8000_0000, 32'd4);
    tick(3);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
